// File: rtl/irq_controller.sv
// N-channel interrupt controller: sync, edge/level capture, masking, pending latches, nested in-service tracking.
// Latency: raw irq_in edge to int_req is two clk edges after the first sync flop captures it.
// Backpressure: a pending request stays presented until int_ack; only a strictly higher channel preempts service.
module irq_controller #(
    parameter int N_IRQ = 3,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic [N_IRQ-1:0] irq_level,
    input  logic             int_ack,
    input  logic             int_done,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic [N_IRQ-1:0] irq_pending,
    output logic [N_IRQ-1:0] irw
);

    logic [N_IRQ-1:0] sync_s1, sync_s2, sync_s3;
    logic [N_IRQ-1:0] irq_evt;
    logic [N_IRQ-1:0] cand;
    logic [N_IRQ-1:0] ack_vec, done_vec;
    logic [ID_W-1:0]  top_p, top_s;
    logic             cand_any, irw_any, ack_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
            sync_s3 <= '0;
        end else begin
            sync_s1 <= irq_in;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
        end
    end

    // Level channels see s2 directly; edge channels see only the rising transition.
    assign irq_evt = sync_s2 & (irq_level | ~sync_s3);
    assign cand    = irq_pending & irq_mask;

    always_comb begin
        top_p    = '0;
        top_s    = '0;
        cand_any = 1'b0;
        irw_any  = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (cand[i]) begin
                top_p    = ID_W'(i);
                cand_any = 1'b1;
            end
            if (irw[i]) begin
                top_s   = ID_W'(i);
                irw_any = 1'b1;
            end
        end
    end

    assign int_req  = cand_any && (!irw_any || (top_p > top_s));
    assign int_id   = int_req ? top_p : '0;
    assign ack_fire = int_ack && int_req;

    always_comb begin
        ack_vec  = '0;
        done_vec = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            ack_vec[i]  = ack_fire && (int_id == ID_W'(i));
            done_vec[i] = int_done && irw_any && (top_s == ID_W'(i));
        end
    end

    // A new event on the acked channel wins over the clear, so held levels re-pend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_pending <= '0;
            irw         <= '0;
        end else begin
            irq_pending <= (irq_pending & ~ack_vec) | irq_evt;
            irw         <= (irw & ~done_vec) | ack_vec;
        end
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised N-channel interrupt controller between raw IRQ sources (buttons, timers, bench stimulus) and the pipelined CPU's interrupt entry/return logic.
- Generalises the fixed 3-bit IRQ/IRW pair:
  - per-channel synchronisation
  - edge or level mode
  - masking
  - pending latches
  - fixed-priority nested in-service tracking
  - ack/done handshake with the CPU

Parameters:
- N_IRQ, 3, number of interrupt channels (1..16).
- ID_W, 2, width of channel index; must satisfy 2^ID_W >= N_IRQ.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq_in  in  N_IRQ  raw requests; asynchronous to clk.
- irq_mask  in  N_IRQ  1 = channel enabled to request; 0 = masked.
- irq_level  in  N_IRQ  1 = level-sensitive; 0 = rising-edge-sensitive.
- int_ack  in  1  CPU accepts the currently presented interrupt (one-cycle pulse).
- int_done  in  1  CPU returns from the current handler (one-cycle pulse).
- int_req  out  1  interrupt request to the CPU.
- int_id  out  ID_W  index of the requested channel; valid while int_req = 1.
- irq_pending  out  N_IRQ  pending latch vector.
- irw  out  N_IRQ  in-service vector: bit i set while handler i is active, including nested handlers.

Behaviour:
- Reset (async, rst = 1): sync stages, pending, irw, int_req and int_id all reset to 0.
- Synchroniser: three flops per channel, s1 <= irq_in, s2 <= s1, s3 <= s2.
  - Edge event: s2 & ~s3.
  - Level event: s2.
- Pending set: pending[i] is set on any clk edge where its event term (selected by irq_level[i]) is 1.
  - Masked channels still latch pending.
- Pending clear: pending[i] clears on int_ack when int_id = i.
  - If set and clear coincide on the same channel, set wins: pending stays 1.
  - Consequence: a level channel held high re-pends immediately after ack.
- Candidates: cand = pending & irq_mask.
- Priority: higher index = higher priority.
  - top_p = highest set bit of cand.
  - top_s = highest set bit of irw; -1 when irw = 0.
- Request outputs (combinational from registered pending/irw and the irq_mask input):
  - int_req = 1 iff cand != 0 and top_p > top_s (nesting only by strictly higher priority).
  - int_id = top_p when int_req = 1, else 0.
- Ack: on an edge with int_ack = 1 and int_req = 1:
  - irw[int_id] <= 1
  - pending[int_id] <= 0, subject to the set-wins rule.
  - int_ack while int_req = 0 is ignored.
- Done: on an edge with int_done = 1 and irw != 0, irw[top_s] <= 0.
  - int_done with irw = 0 is ignored.
- Ack and done in the same cycle:
  - The done clear uses the pre-edge irw.
  - The ack bit is then OR-ed in.
  - int_id is evaluated from pre-edge state.
- Latency: irq_in rising just before edge t0 (edge channel, enabled, irw = 0):
  - s2 = 1 after t0+1.
  - pending and int_req = 1 after t0+2.
- Edge channel: a pulse shorter than one clk period may be lost; a high level held at least 2 periods is guaranteed to be captured exactly once per rising transition.
- Mask change takes effect combinationally on int_req/int_id in the same cycle; pending is unaffected.
- Reset mid-handler clears irw and pending; no request survives reset.

Test Plan:
1. Reset: rst pulse with irq_in = 3'b111 -> all outputs 0 during reset. After release, edge mode, mask 3'b111: int_req = 1 three edges later with int_id = 2, irq_pending = 3'b111.
2. Priority/ack: pending 3'b011, int_ack -> irw = 3'b010, pending = 3'b001, int_req = 0 (ch0 lower than in-service ch1). int_done -> irw = 0, then int_req = 1 with int_id = 0.
3. Nesting: in service ch0 (irw = 3'b001); edge on ch2 -> int_req = 1, int_id = 2. Ack -> irw = 3'b101. Two int_done pulses clear bit 2 then bit 0.
4. Mask: mask = 3'b011, edge on ch2 -> irq_pending[2] = 1, int_req = 0. Set mask = 3'b111 -> int_req = 1, int_id = 2 in the same cycle.
5. Level vs edge: ch1 level mode held high, ack -> pending[1] stays 1. ch1 edge mode held high, ack -> pending[1] = 0 and no re-pend until irq_in[1] falls and rises again.
6. Corner cases:
   - int_ack with int_req = 0 -> no change.
   - int_done with irw = 0 -> no change.
   - Simultaneous int_done (irw = 3'b001) and int_ack (int_id = 2) -> irw = 3'b100.
   - N_IRQ = 8 build: edge on ch7 preempts irw = 8'h40.
